// File: rtl/pc_pkg.sv
// pc_pkg: shared PC width, reset address, pc type and fetch state encoding
package pc_pkg;
  localparam int PC_W_DEF = 36;
  typedef logic [PC_W_DEF-1:0] pc_t;
  localparam pc_t PC_RESET = '0;
  typedef enum logic [1:0] {BOOT, RUN, HOLD} state_t;
endpackage

// File: rtl/pc_redirect_buf.sv
// pc_redirect_buf: holds an EX redirect raised during a stall until fetch can apply it
module pc_redirect_buf
  import pc_pkg::*;
#(
  parameter int W = PC_W_DEF
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_set,
  input  logic         i_clr,
  input  logic [W-1:0] i_tgt,
  output logic         o_valid,
  output logic [W-1:0] o_tgt
);
  logic         valid_d, valid_q;
  logic [W-1:0] tgt_d, tgt_q;
  // a new redirect always overwrites the held one; apply clears it
  always_comb begin
    valid_d = i_set ? 1'b1 : i_clr ? 1'b0 : valid_q;
    tgt_d   = i_set ? i_tgt : tgt_q;
  end
  // pending register with synchronous active-low clear
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      valid_q <= 1'b0;
      tgt_q   <= '0;
    end else begin
      valid_q <= valid_d;
      tgt_q   <= tgt_d;
    end
  end
  assign o_valid = valid_q;
  assign o_tgt   = tgt_q;
endmodule

// File: rtl/pc_ctrl.sv
// pc_ctrl: fetch PC sequencer (BOOT/RUN/HOLD), EX redirects, optional backward-taken prediction under PC_BPRED_EN
module pc_ctrl
  import pc_pkg::*;
#(
  parameter int              PC_W     = PC_W_DEF,
  parameter logic [PC_W-1:0] RESET_PC = PC_W'(PC_RESET)
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_stall,
  input  logic            i_imem_ready,
  output logic            o_imem_req,
  output logic [PC_W-1:0] o_pc,
  input  logic            i_ex_redirect,
  input  logic [PC_W-1:0] i_ex_target,
  input  logic            i_dec_br_valid,
  input  logic            i_dec_br_bwd,
  input  logic [PC_W-1:0] i_dec_br_target,
  output logic            o_flush_if,
  output logic            o_pred_taken
);
  state_t          state_d, state_q;
  logic [PC_W-1:0] pc_d, pc_q, pend_tgt, redir_tgt;
  logic            req_d, req_q, flush_d, flush_q, pred_d, pred_q;
  logic            pend_valid, hs, live, redir, pred;

  pc_redirect_buf #(.W(PC_W)) u_buf (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_set   (i_ex_redirect & i_stall),
    .i_clr   (pend_valid & ~i_stall),
    .i_tgt   (i_ex_target),
    .o_valid (pend_valid),
    .o_tgt   (pend_tgt)
  );

  assign hs        = req_q & i_imem_ready & ~i_stall;
  assign live      = i_ex_redirect & ~i_stall;
  assign redir     = live | (pend_valid & ~i_stall);
  assign redir_tgt = live ? i_ex_target : pend_tgt;

`ifdef PC_BPRED_EN
  assign pred = i_dec_br_valid & i_dec_br_bwd & ~i_stall & ~i_ex_redirect & ~pend_valid;
`else
  logic unused_dec;
  assign unused_dec = ^{i_dec_br_valid, i_dec_br_bwd, i_dec_br_target};
  assign pred = 1'b0;
`endif

  // next-PC priority: redirect, prediction, handshake advance, hold
  always_comb begin
    pc_d    = redir ? redir_tgt : pred ? i_dec_br_target : hs ? pc_q + PC_W'(1) : pc_q;
    state_d = (state_q == BOOT || redir || pred || hs) ? RUN : HOLD;
    req_d   = 1'b1;
    flush_d = redir | pred;
    pred_d  = pred;
  end

  // state and registered outputs
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q <= BOOT;
      pc_q    <= RESET_PC;
      req_q   <= 1'b0;
      flush_q <= 1'b0;
      pred_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      req_q   <= req_d;
      flush_q <= flush_d;
      pred_q  <= pred_d;
    end
  end

  assign o_pc         = pc_q;
  assign o_imem_req   = req_q;
  assign o_flush_if   = flush_q;
  assign o_pred_taken = pred_q;
endmodule
